game_flow_ctrl: RTL and testbench

//  Parametrised game-flow sequencer for the symbol-counting game. Replaces the fixed chain of prelim/game/answer/post periods with one FSM.

---
 rtl/game_flow_ctrl_if.sv | 33 +++
 rtl/game_flow_ctrl.sv | 175 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_if.sv
// Handshake and status bundle between the game-flow sequencer and its surroundings
// (symbol generator, button debouncers, display mux).
interface game_flow_ctrl_if #(
    parameter int COUNT_W = 8,
    parameter int LVL_W   = 4
);
    logic               start;
    logic               tick1Hz;
    logic               userUp;
    logic               userDown;
    logic [COUNT_W-1:0] magicCount;
    logic               startGen;
    logic               stopGen;
    logic [2:0]         phase;
    logic [7:0]         secsLeft;
    logic [COUNT_W-1:0] userCount;
    logic [COUNT_W-1:0] difference;
    logic [LVL_W-1:0]   level;
    logic [2:0]         lives;
    logic [31:0]        symGenMax;

    modport master (
        output start, tick1Hz, userUp, userDown, magicCount,
        input  startGen, stopGen, phase, secsLeft, userCount, difference,
               level, lives, symGenMax
    );

    modport slave (
        input  start, tick1Hz, userUp, userDown, magicCount,
        output startGen, stopGen, phase, secsLeft, userCount, difference,
               level, lives, symGenMax
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer for the symbol-counting game: one FSM walking PRELIM/GAME/ANSWER/POST
// per level, with per-phase timers, user tally, scoring, lives/retry and generator rate.
module game_flow_ctrl #(
    parameter int          COUNT_W     = 8,
    parameter int          LVL_W       = 4,
    parameter int          NUM_LEVELS  = 8,
    parameter int          LIVES       = 3,
    parameter int          TOL         = 0,
    parameter int          PRELIM_SECS = 3,
    parameter int          GAME_SECS   = 20,
    parameter int          ANSWER_SECS = 10,
    parameter int          POST_SECS   = 3,
    parameter int unsigned GEN_BASE    = 100000000,
    parameter int unsigned GEN_STEP    = 8000000,
    parameter int unsigned GEN_MIN     = 20000000
) (
    input  logic          Clk100M,
    input  logic          reset,
    game_flow_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRELIM = 3'd1;
    localparam logic [2:0] GAME   = 3'd2;
    localparam logic [2:0] ANSWER = 3'd3;
    localparam logic [2:0] POST   = 3'd4;
    localparam logic [2:0] WIN    = 3'd5;
    localparam logic [2:0] LOSE   = 3'd6;

    localparam logic [7:0]         prelimLoad = 8'(PRELIM_SECS);
    localparam logic [7:0]         gameLoad   = 8'(GAME_SECS);
    localparam logic [7:0]         answerLoad = 8'(ANSWER_SECS);
    localparam logic [7:0]         postLoad   = 8'(POST_SECS);
    localparam logic [COUNT_W-1:0] countMax   = '1;
    localparam logic [COUNT_W-1:0] tolVal     = COUNT_W'(TOL);
    localparam logic [LVL_W-1:0]   lastLevel  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [2:0]         livesInit  = 3'(LIVES);

    logic [2:0]         phaseQ;
    logic [7:0]         secsLeftQ;
    logic [COUNT_W-1:0] userCountQ;
    logic [COUNT_W-1:0] differenceQ;
    logic [LVL_W-1:0]   levelQ;
    logic [2:0]         livesQ;
    logic [31:0]        symGenMaxQ;
    logic               startGenQ;
    logic               stopGenQ;
    logic               timedPhase;
    logic               tickEnd;

    // Generator period shrinks linearly with level, clamped at the floor (also guards underflow).
    function automatic logic [31:0] genMaxFor(input logic [LVL_W-1:0] lvl);
        logic [63:0] dec;
        logic [63:0] base;
        logic [63:0] floorVal;
        dec      = 64'(lvl) * 64'(GEN_STEP);
        base     = 64'(GEN_BASE);
        floorVal = 64'(GEN_MIN);
        if (dec >= base || (base - dec) < floorVal)
            return floorVal[31:0];
        return 32'(base - dec);
    endfunction

    function automatic logic [COUNT_W-1:0] absDiff(input logic [COUNT_W-1:0] a,
                                                   input logic [COUNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [COUNT_W-1:0] tallyStep(input logic [COUNT_W-1:0] cnt,
                                                     input logic up, input logic down);
        if (up && !down && cnt != countMax)
            return cnt + 1'b1;
        if (down && !up && cnt != '0)
            return cnt - 1'b1;
        return cnt;
    endfunction

    assign timedPhase = (phaseQ == PRELIM) || (phaseQ == GAME) ||
                        (phaseQ == ANSWER) || (phaseQ == POST);
    assign tickEnd    = timedPhase && bus.tick1Hz && (secsLeftQ == 8'd1);

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            phaseQ      <= IDLE;
            secsLeftQ   <= '0;
            userCountQ  <= '0;
            differenceQ <= '0;
            levelQ      <= '0;
            livesQ      <= livesInit;
            symGenMaxQ  <= GEN_BASE;
            startGenQ   <= 1'b0;
            stopGenQ    <= 1'b0;
        end else begin
            startGenQ  <= 1'b0;
            stopGenQ   <= 1'b0;
            symGenMaxQ <= genMaxFor(levelQ);

            if (phaseQ == GAME || phaseQ == ANSWER)
                userCountQ <= tallyStep(userCountQ, bus.userUp, bus.userDown);

            if (timedPhase && bus.tick1Hz && !tickEnd)
                secsLeftQ <= secsLeftQ - 8'd1;

            case (phaseQ)
                IDLE, WIN, LOSE: begin
                    if (bus.start) begin
                        phaseQ      <= PRELIM;
                        secsLeftQ   <= prelimLoad;
                        levelQ      <= '0;
                        livesQ      <= livesInit;
                        differenceQ <= '0;
                    end
                end
                PRELIM: begin
                    if (tickEnd) begin
                        phaseQ     <= GAME;
                        secsLeftQ  <= gameLoad;
                        userCountQ <= '0;
                        startGenQ  <= 1'b1;
                    end
                end
                GAME: begin
                    if (tickEnd) begin
                        phaseQ    <= ANSWER;
                        secsLeftQ <= answerLoad;
                        stopGenQ  <= 1'b1;
                    end
                end
                ANSWER: begin
                    if (tickEnd) begin
                        phaseQ      <= POST;
                        secsLeftQ   <= postLoad;
                        differenceQ <= absDiff(userCountQ, bus.magicCount);
                    end
                end
                POST: begin
                    if (tickEnd) begin
                        if (differenceQ <= tolVal) begin
                            if (levelQ == lastLevel) begin
                                phaseQ    <= WIN;
                                secsLeftQ <= '0;
                            end else begin
                                levelQ    <= levelQ + 1'b1;
                                phaseQ    <= PRELIM;
                                secsLeftQ <= prelimLoad;
                            end
                        end else begin
                            livesQ <= livesQ - 3'd1;
                            if (livesQ == 3'd1) begin
                                phaseQ    <= LOSE;
                                secsLeftQ <= '0;
                            end else begin
                                phaseQ    <= PRELIM;
                                secsLeftQ <= prelimLoad;
                            end
                        end
                    end
                end
                default: begin
                    phaseQ    <= IDLE;
                    secsLeftQ <= '0;
                end
            endcase
        end
    end

    assign bus.phase      = phaseQ;
    assign bus.secsLeft   = secsLeftQ;
    assign bus.userCount  = userCountQ;
    assign bus.difference = differenceQ;
    assign bus.level      = levelQ;
    assign bus.lives      = livesQ;
    assign bus.symGenMax  = symGenMaxQ;
    assign bus.startGen   = startGenQ;
    assign bus.stopGen    = stopGenQ;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short phases (2/3/2/1 s), two levels and two lives.
module tb_game_flow_ctrl;
    logic Clk100M = 1'b0;
    logic reset   = 1'b1;
    int   nChecks = 0;
    int   nPassed = 0;

    always #5 Clk100M = ~Clk100M;

    game_flow_ctrl_if #(.COUNT_W(8), .LVL_W(4)) bus ();

    game_flow_ctrl #(
        .COUNT_W(8), .LVL_W(4), .NUM_LEVELS(2), .LIVES(2), .TOL(0),
        .PRELIM_SECS(2), .GAME_SECS(3), .ANSWER_SECS(2), .POST_SECS(1)
    ) dut (
        .Clk100M(Clk100M),
        .reset  (reset),
        .bus    (bus.slave)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            nPassed++;
    endtask

    task automatic step();
        @(posedge Clk100M);
        #1;
    endtask

    task automatic pulseTick();
        bus.tick1Hz = 1'b1; step(); bus.tick1Hz = 1'b0;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic pulseUp(input int n);
        for (int i = 0; i < n; i++) begin
            bus.userUp = 1'b1; step(); bus.userUp = 1'b0;
        end
    endtask

    task automatic pulseDown();
        bus.userDown = 1'b1; step(); bus.userDown = 1'b0;
    endtask

    task automatic pulseBoth();
        bus.userUp = 1'b1; bus.userDown = 1'b1; step();
        bus.userUp = 1'b0; bus.userDown = 1'b0;
    endtask

    // From a fresh PRELIM entry: run PRELIM, press `ups` times in GAME, run GAME and ANSWER; ends in POST.
    task automatic runRound(input int ups);
        pulseTick(); pulseTick();
        pulseUp(ups);
        pulseTick(); pulseTick(); pulseTick();
        pulseTick(); pulseTick();
    endtask

    initial begin
        bus.start = 1'b0; bus.tick1Hz = 1'b0; bus.userUp = 1'b0; bus.userDown = 1'b0;
        bus.magicCount = 8'd5;
        step(); step();
        reset = 1'b0;
        checkVal("rst phase", 32'(bus.phase), 0);
        checkVal("rst secsLeft", 32'(bus.secsLeft), 0);
        checkVal("rst userCount", 32'(bus.userCount), 0);
        checkVal("rst difference", 32'(bus.difference), 0);
        checkVal("rst level", 32'(bus.level), 0);
        checkVal("rst lives", 32'(bus.lives), 2);
        checkVal("rst startGen", 32'(bus.startGen), 0);
        checkVal("rst stopGen", 32'(bus.stopGen), 0);
        checkVal("rst symGenMax", bus.symGenMax, 100000000);

        pulseTick();
        checkVal("idle tick ignored", 32'(bus.phase), 0);
        pulseStart();
        checkVal("t1 phase prelim", 32'(bus.phase), 1);
        checkVal("t1 secs prelim", 32'(bus.secsLeft), 2);
        pulseTick();
        checkVal("t1 secs dec", 32'(bus.secsLeft), 1);
        checkVal("t1 no startGen yet", 32'(bus.startGen), 0);
        pulseTick();
        checkVal("t1 phase game", 32'(bus.phase), 2);
        checkVal("t1 startGen", 32'(bus.startGen), 1);
        checkVal("t1 secs game", 32'(bus.secsLeft), 3);
        checkVal("t1 userCount", 32'(bus.userCount), 0);
        step();
        checkVal("t1 startGen one cycle", 32'(bus.startGen), 0);

        pulseUp(4);
        checkVal("t2 userCount 4", 32'(bus.userCount), 4);
        pulseTick(); pulseTick(); pulseTick();
        checkVal("t2 phase answer", 32'(bus.phase), 3);
        checkVal("t2 stopGen", 32'(bus.stopGen), 1);
        step();
        checkVal("t2 stopGen one cycle", 32'(bus.stopGen), 0);
        pulseUp(1);
        checkVal("t2 userCount 5", 32'(bus.userCount), 5);
        pulseTick(); pulseTick();
        checkVal("t2 phase post", 32'(bus.phase), 4);
        checkVal("t2 difference", 32'(bus.difference), 0);
        pulseTick();
        checkVal("t2 phase prelim", 32'(bus.phase), 1);
        checkVal("t2 level", 32'(bus.level), 1);
        checkVal("t2 symGenMax lag", bus.symGenMax, 100000000);
        step();
        checkVal("t2 symGenMax lvl1", bus.symGenMax, 92000000);

        runRound(3);
        checkVal("t3 difference", 32'(bus.difference), 2);
        pulseTick();
        checkVal("t3 phase retry", 32'(bus.phase), 1);
        checkVal("t3 lives", 32'(bus.lives), 1);
        checkVal("t3 level kept", 32'(bus.level), 1);
        runRound(3);
        pulseTick();
        checkVal("t3 phase lose", 32'(bus.phase), 6);
        checkVal("t3 lives 0", 32'(bus.lives), 0);
        checkVal("t3 secs lose", 32'(bus.secsLeft), 0);
        pulseTick();
        checkVal("t3 lose holds", 32'(bus.phase), 6);
        pulseStart();
        checkVal("t3 restart phase", 32'(bus.phase), 1);
        checkVal("t3 restart level", 32'(bus.level), 0);
        checkVal("t3 restart lives", 32'(bus.lives), 2);
        checkVal("t3 restart diff", 32'(bus.difference), 0);

        pulseUp(1);
        checkVal("t5 prelim press ignored", 32'(bus.userCount), 3);
        pulseTick(); pulseTick();
        checkVal("t5 game cleared", 32'(bus.userCount), 0);
        pulseDown();
        checkVal("t5 down at 0", 32'(bus.userCount), 0);
        pulseBoth();
        checkVal("t5 both at 0", 32'(bus.userCount), 0);
        pulseUp(1);
        pulseBoth();
        checkVal("t5 both at 1", 32'(bus.userCount), 1);
        pulseUp(260);
        checkVal("t5 sat 255", 32'(bus.userCount), 255);
        pulseBoth();
        checkVal("t5 both at 255", 32'(bus.userCount), 255);
        pulseDown();
        checkVal("t5 down 254", 32'(bus.userCount), 254);
        pulseTick(); pulseTick(); pulseTick(); pulseTick(); pulseTick();
        checkVal("t5 phase post", 32'(bus.phase), 4);
        checkVal("t5 difference", 32'(bus.difference), 249);
        pulseUp(1);
        checkVal("t5 post press ignored", 32'(bus.userCount), 254);
        pulseTick();
        checkVal("t5 lives", 32'(bus.lives), 1);
        checkVal("t5 phase retry", 32'(bus.phase), 1);

        reset = 1'b1; step(); reset = 1'b0;
        pulseStart();
        runRound(5);
        checkVal("t4 pass1 diff", 32'(bus.difference), 0);
        pulseTick();
        checkVal("t4 level 1", 32'(bus.level), 1);
        runRound(5);
        pulseTick();
        checkVal("t4 phase win", 32'(bus.phase), 5);
        checkVal("t4 win level", 32'(bus.level), 1);
        checkVal("t4 win lives", 32'(bus.lives), 2);
        pulseTick();
        checkVal("t4 win holds", 32'(bus.phase), 5);
        checkVal("t4 win secs", 32'(bus.secsLeft), 0);
        pulseStart();
        checkVal("t4 restart phase", 32'(bus.phase), 1);
        checkVal("t4 restart level", 32'(bus.level), 0);
        checkVal("t4 restart lives", 32'(bus.lives), 2);

        runRound(5);
        pulseTick();
        pulseTick(); pulseTick();
        pulseTick(); pulseTick();
        checkVal("t6 game secs 1", 32'(bus.secsLeft), 1);
        checkVal("t6 symGenMax lvl1", bus.symGenMax, 92000000);
        reset = 1'b1; bus.tick1Hz = 1'b1;
        step();
        reset = 1'b0; bus.tick1Hz = 1'b0;
        checkVal("t6 phase idle", 32'(bus.phase), 0);
        checkVal("t6 lives", 32'(bus.lives), 2);
        checkVal("t6 level", 32'(bus.level), 0);
        checkVal("t6 no stopGen", 32'(bus.stopGen), 0);
        checkVal("t6 symGenMax", bus.symGenMax, 100000000);
        checkVal("t6 secsLeft", 32'(bus.secsLeft), 0);
        step();
        checkVal("t6 no late stopGen", 32'(bus.stopGen), 0);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end
endmodule
